// File: rtl/step_move_controller.sv
// Stepper move sequencer: accepts direction/step-count commands, drives the stepper
// interface enable/direction, counts steps on a matched divider and tracks position.
module step_move_controller #(
  parameter int unsigned STEP_DIV   = 50000,
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned POS_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             abort,
  input  logic             limit_fwd,
  input  logic             limit_rev,
  output logic             motor_en,
  output logic             motor_dir,
  output logic             step_tick,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [POS_W-1:0] position,
  output logic [CNT_W-1:0] steps_left
);

  localparam int unsigned DIV_W = $clog2(STEP_DIV);
  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(STEP_DIV - 2);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StRun, StDone} state_e;
  typedef enum logic [1:0] {StatOk = 2'b00, StatLimit = 2'b01, StatAbort = 2'b10} status_e;

  state_e           state_q, state_d;
  status_e          status_q, status_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SET_W-1:0] set_q, set_d;
  logic             motor_dir_q, motor_dir_d;
  logic             step_tick_q, step_tick_d;
  logic [POS_W-1:0] position_q, position_d;
  logic [CNT_W-1:0] steps_left_q, steps_left_d;
  logic             limit_hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      status_q     <= StatOk;
      div_q        <= '0;
      set_q        <= '0;
      motor_dir_q  <= 1'b0;
      step_tick_q  <= 1'b0;
      position_q   <= '0;
      steps_left_q <= '0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      div_q        <= div_d;
      set_q        <= set_d;
      motor_dir_q  <= motor_dir_d;
      step_tick_q  <= step_tick_d;
      position_q   <= position_d;
      steps_left_q <= steps_left_d;
    end
  end

  // Only the end-stop in the direction of travel can stop a move.
  assign limit_hit = motor_dir_q ? limit_fwd : limit_rev;

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    div_d        = '0;
    set_d        = '0;
    motor_dir_d  = motor_dir_q;
    step_tick_d  = 1'b0;
    position_d   = position_q;
    steps_left_d = steps_left_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          steps_left_d = cmd_steps;
          status_d     = StatOk;
          if (cmd_steps == '0) begin
            state_d = StDone;
          end else if (cmd_dir ? limit_fwd : limit_rev) begin
            status_d = StatLimit;
            state_d  = StDone;
          end else if (cmd_dir != motor_dir_q) begin
            motor_dir_d = cmd_dir;
            state_d     = StSettle;
          end else begin
            state_d = StRun;
          end
        end
      end

      StSettle: begin
        if (abort) begin
          status_d = StatAbort;
          state_d  = StDone;
        end else if (set_q == SET_LAST) begin
          state_d = StRun;
        end else begin
          set_d = set_q + 1'b1;
        end
      end

      StRun: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        if (limit_hit) begin
          status_d = StatLimit;
          state_d  = StDone;
        end else begin
          // Step is registered one cycle early so step_tick lines up with divider terminal count.
          if (div_q == DIV_PRE) begin
            step_tick_d  = 1'b1;
            steps_left_d = steps_left_q - 1'b1;
            position_d   = motor_dir_q ? position_q + 1'b1 : position_q - 1'b1;
            if (steps_left_q == CNT_W'(1)) state_d = StDone;
          end
          if (abort) begin
            status_d = StatAbort;
            state_d  = StDone;
          end
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  assign cmd_ready  = (state_q == StIdle);
  assign motor_en   = (state_q == StRun);
  assign busy       = (state_q == StSettle) || (state_q == StRun);
  assign done       = (state_q == StDone);
  assign motor_dir  = motor_dir_q;
  assign step_tick  = step_tick_q;
  assign status     = status_q;
  assign position   = position_q;
  assign steps_left = steps_left_q;

endmodule

// File: tb/tb_step_move_controller.sv
// Directed bench for step_move_controller with STEP_DIV=4, SETTLE_CYC=3.
module tb_step_move_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic        abort = 1'b0;
  logic        limit_fwd = 1'b0;
  logic        limit_rev = 1'b0;
  logic        motor_en, motor_dir, step_tick, busy, done;
  logic [1:0]  status;
  logic [15:0] position, steps_left;

  int vecs = 0;
  int errs = 0;

  step_move_controller #(
    .STEP_DIV  (4),
    .SETTLE_CYC(3),
    .CNT_W     (16),
    .POS_W     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .abort     (abort),
    .limit_fwd (limit_fwd),
    .limit_rev (limit_rev),
    .motor_en  (motor_en),
    .motor_dir (motor_dir),
    .step_tick (step_tick),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .position  (position),
    .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge; returns in the first cycle after acceptance.
  task automatic accept(input logic dir, input logic [15:0] steps);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = steps;
    step();
    cmd_valid = 1'b0;
  endtask

  // Follows a move until done, checking tick spacing; cyc=1 is the cycle after accept.
  task automatic wait_done(input int budget, input string tag, output int cyc,
                           output int nticks, output int first_tick);
    int last;
    bit fin;
    cyc = 1; nticks = 0; first_tick = 0; last = 0; fin = 0;
    while (!fin) begin
      if (step_tick) begin
        if (nticks == 0) first_tick = cyc;
        else begin
          vecs++;
          if (cyc - last != 4) begin
            errs++;
            $display("FAIL %s_tick_gap: got %0d cycles want 4", tag, cyc - last);
          end
        end
        last = cyc;
        nticks++;
      end
      if (done) fin = 1;
      else if (cyc >= budget) begin
        vecs++; errs++;
        $display("FAIL %s_timeout: no done within %0d cycles", tag, budget);
        fin = 1;
      end else begin
        step();
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    vecs++;
    if ({motor_en, motor_dir, step_tick, busy, done} !== 5'b0) begin
      errs++; $display("FAIL reset_ctrl: got %b want 00000",
                       {motor_en, motor_dir, step_tick, busy, done});
    end
    vecs++;
    if (status !== 2'b00 || position !== 16'd0 || steps_left !== 16'd0) begin
      errs++; $display("FAIL reset_regs: got status=%b pos=%0d left=%0d want 0/0/0",
                       status, position, steps_left);
    end
    rst = 1'b1;
    vecs++;
    if (cmd_ready !== 1'b1) begin
      errs++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_settle_move();
    int cyc, nt, ft;
    accept(1'b1, 16'd3);
    vecs++;
    if (motor_en !== 1'b0 || busy !== 1'b1 || motor_dir !== 1'b1 || cmd_ready !== 1'b0) begin
      errs++; $display("FAIL settle_entry: got en=%b busy=%b dir=%b rdy=%b want 0 1 1 0",
                       motor_en, busy, motor_dir, cmd_ready);
    end
    wait_done(40, "settle", cyc, nt, ft);
    vecs++;
    if (ft !== 7 || nt !== 3 || cyc !== 15) begin
      errs++; $display("FAIL settle_timing: got first=%0d ticks=%0d done=%0d want 7 3 15",
                       ft, nt, cyc);
    end
    vecs++;
    if (status !== 2'b00 || position !== 16'd3 || steps_left !== 16'd0) begin
      errs++; $display("FAIL settle_result: got status=%b pos=%0d left=%0d want 00 3 0",
                       status, position, steps_left);
    end
    step();
    vecs++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL settle_idle: got done=%b rdy=%b busy=%b want 0 1 0",
                       done, cmd_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nt, ft;
    accept(1'b1, 16'd2);
    vecs++;
    if (motor_en !== 1'b1 || busy !== 1'b1) begin
      errs++; $display("FAIL b2b_en: got en=%b busy=%b want 1 1", motor_en, busy);
    end
    wait_done(40, "b2b", cyc, nt, ft);
    vecs++;
    if (ft !== 4 || nt !== 2 || cyc !== 8) begin
      errs++; $display("FAIL b2b_timing: got first=%0d ticks=%0d done=%0d want 4 2 8",
                       ft, nt, cyc);
    end
    vecs++;
    if (position !== 16'd5 || status !== 2'b00) begin
      errs++; $display("FAIL b2b_result: got pos=%0d status=%b want 5 00", position, status);
    end
    step();
  endtask

  task automatic test_limit_rev();
    int nt;
    bit fin;
    accept(1'b0, 16'd10);
    nt = 0; fin = 0;
    for (int cyc = 1; cyc < 60 && !fin; cyc++) begin
      if (done) begin
        vecs++; errs++;
        $display("FAIL limit_early_done: got done at tick %0d want after 4", nt);
        fin = 1;
      end else begin
        if (step_tick) nt++;
        if (nt == 4 && step_tick) begin
          limit_rev = 1'b1;
          fin = 1;
        end else begin
          limit_fwd = ~limit_fwd;
        end
        step();
      end
    end
    vecs++;
    if (done !== 1'b1 || motor_en !== 1'b0 || status !== 2'b01 || step_tick !== 1'b0) begin
      errs++; $display("FAIL limit_stop: got done=%b en=%b status=%b tick=%b want 1 0 01 0",
                       done, motor_en, status, step_tick);
    end
    vecs++;
    if (position !== 16'd1 || steps_left !== 16'd6) begin
      errs++; $display("FAIL limit_result: got pos=%0d left=%0d want 1 6",
                       position, steps_left);
    end
    limit_rev = 1'b0;
    limit_fwd = 1'b0;
    step();
  endtask

  task automatic test_abort_tick();
    int nt;
    bit fin;
    accept(1'b1, 16'd5);
    nt = 0; fin = 0;
    for (int cyc = 1; cyc < 60 && !fin; cyc++) begin
      if (step_tick) nt++;
      if (nt == 2) begin
        abort = 1'b1;
        fin = 1;
      end
      step();
    end
    vecs++;
    if (done !== 1'b1 || status !== 2'b10 || motor_en !== 1'b0) begin
      errs++; $display("FAIL abort_stop: got done=%b status=%b en=%b want 1 10 0",
                       done, status, motor_en);
    end
    vecs++;
    if (position !== 16'd3 || steps_left !== 16'd3) begin
      errs++; $display("FAIL abort_result: got pos=%0d left=%0d want 3 3",
                       position, steps_left);
    end
    abort = 1'b0;
    step();
  endtask

  task automatic test_tick_limit_same();
    accept(1'b1, 16'd5);
    step(); step(); step();
    vecs++;
    if (step_tick !== 1'b1 || position !== 16'd4) begin
      errs++; $display("FAIL tl_first_tick: got tick=%b pos=%0d want 1 4", step_tick, position);
    end
    step(); step(); step();
    limit_fwd = 1'b1;
    step();
    vecs++;
    if (done !== 1'b1 || status !== 2'b01 || step_tick !== 1'b0) begin
      errs++; $display("FAIL tl_stop: got done=%b status=%b tick=%b want 1 01 0",
                       done, status, step_tick);
    end
    vecs++;
    if (position !== 16'd4 || steps_left !== 16'd4) begin
      errs++; $display("FAIL tl_suppress: got pos=%0d left=%0d want 4 4", position, steps_left);
    end
    limit_fwd = 1'b0;
    step();
  endtask

  task automatic test_immediate_done();
    abort = 1'b1;
    accept(1'b1, 16'd0);
    vecs++;
    if (done !== 1'b1 || status !== 2'b00 || motor_en !== 1'b0 || step_tick !== 1'b0) begin
      errs++; $display("FAIL zero_done: got done=%b status=%b en=%b tick=%b want 1 00 0 0",
                       done, status, motor_en, step_tick);
    end
    abort = 1'b0;
    step();
    limit_fwd = 1'b1;
    accept(1'b1, 16'd7);
    vecs++;
    if (done !== 1'b1 || status !== 2'b01 || motor_en !== 1'b0 || steps_left !== 16'd7) begin
      errs++; $display("FAIL lim_done: got done=%b status=%b en=%b left=%0d want 1 01 0 7",
                       done, status, motor_en, steps_left);
    end
    step();
    vecs++;
    if (status !== 2'b01 || motor_en !== 1'b0 || position !== 16'd4 || cmd_ready !== 1'b1) begin
      errs++; $display("FAIL lim_hold: got status=%b en=%b pos=%0d rdy=%b want 01 0 4 1",
                       status, motor_en, position, cmd_ready);
    end
    limit_fwd = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int cyc, nt, ft;
    bit seen_done;
    accept(1'b1, 16'd4);
    step(); step(); step(); step();
    rst = 1'b0;
    step();
    vecs++;
    if ({motor_en, motor_dir, step_tick, busy, done} !== 5'b0 || status !== 2'b00) begin
      errs++; $display("FAIL rst_run_ctrl: got %b status=%b want 00000 00",
                       {motor_en, motor_dir, step_tick, busy, done}, status);
    end
    vecs++;
    if (position !== 16'd0 || steps_left !== 16'd0) begin
      errs++; $display("FAIL rst_run_regs: got pos=%0d left=%0d want 0 0", position, steps_left);
    end
    rst = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) seen_done = 1;
    end
    vecs++;
    if (seen_done !== 1'b0 || cmd_ready !== 1'b1) begin
      errs++; $display("FAIL rst_run_after: got done_seen=%b rdy=%b want 0 1",
                       seen_done, cmd_ready);
    end
    // One reverse step from zero wraps the position.
    accept(1'b0, 16'd1);
    wait_done(20, "wrap", cyc, nt, ft);
    vecs++;
    if (cyc !== 4 || nt !== 1 || position !== 16'hFFFF || status !== 2'b00) begin
      errs++; $display("FAIL wrap: got done=%0d ticks=%0d pos=%h status=%b want 4 1 ffff 00",
                       cyc, nt, position, status);
    end
  endtask

  initial begin
    test_reset();
    test_settle_move();
    test_back_to_back();
    test_limit_rev();
    test_abort_tick();
    test_tick_limit_same();
    test_immediate_done();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
